dds_phase_gen: RTL and testbench

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

---
 rtl/dds_phase_gen.sv | 126 ++++++++++++
 tb/tb_dds_phase_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// Phase accumulator for a CORDIC-driven DDS: produces angle samples in centidegrees
// (0..35999) with a fixed or linearly swept tuning word.
module dds_phase_gen #(
  parameter int FRAC_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [15+FRAC_W:0]  cfg_ftw,
  input  logic [15:0]         cfg_phase,
  input  logic                cfg_sweep,
  input  logic [15+FRAC_W:0]  cfg_step,
  input  logic [15+FRAC_W:0]  cfg_stop,
  input  logic [15:0]         cfg_dwell,
  output logic [15:0]         angle,
  output logic                angle_valid,
  output logic                sync,
  output logic                busy,
  output logic                cfg_err
);

  localparam int ACC_W = 16 + FRAC_W;
  localparam logic [ACC_W:0] MOD = (ACC_W + 1)'(36000) << FRAC_W;

  typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw;
  logic [ACC_W-1:0]   step;
  logic [ACC_W-1:0]   stop;
  logic [15:0]        offset;
  logic [15:0]        dwell;
  logic [15:0]        dwell_cnt;
  logic               sync_pend;

  // Accumulator sum is one bit wider so the modulo compare never sees a wrapped value.
  logic [ACC_W:0]     acc_sum;
  logic               wrap;
  logic [ACC_W-1:0]   acc_next;
  logic [16:0]        angle_sum;
  logic [15:0]        angle_next;
  logic [ACC_W:0]     ftw_sum;
  logic [ACC_W-1:0]   ftw_sat;
  logic [15:0]        dwell_max;
  logic               dwell_hit;
  logic               cfg_fire;
  logic               cfg_bad;
  logic               advance;

  assign acc_sum    = {1'b0, acc} + {1'b0, ftw};
  assign wrap       = (acc_sum >= MOD);
  assign acc_next   = wrap ? ACC_W'(acc_sum - MOD) : acc_sum[ACC_W-1:0];

  assign angle_sum  = {1'b0, acc[ACC_W-1:FRAC_W]} + {1'b0, offset};
  assign angle_next = (angle_sum >= 17'd36000) ? 16'(angle_sum - 17'd36000)
                                               : angle_sum[15:0];

  // Saturating step: the wide sum cannot overflow, so clamping at stop is exact.
  assign ftw_sum    = {1'b0, ftw} + {1'b0, step};
  assign ftw_sat    = (ftw_sum >= {1'b0, stop}) ? stop : ftw_sum[ACC_W-1:0];

  assign dwell_max  = (dwell == 16'd0) ? 16'd1 : dwell;
  assign dwell_hit  = (({1'b0, dwell_cnt} + 17'd1) == {1'b0, dwell_max});

  assign cfg_ready  = (state != SWEEP);
  assign busy       = (state == SWEEP);
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign cfg_bad    = (cfg_ftw[ACC_W-1:FRAC_W] >= 16'd36000) ||
                      (cfg_phase >= 16'd36000) ||
                      (cfg_sweep && (cfg_stop[ACC_W-1:FRAC_W] >= 16'd36000));
  assign advance    = (state != IDLE) && en;

  // NOTE: all state updates use non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      ftw         <= '0;
      step        <= '0;
      stop        <= '0;
      offset      <= '0;
      dwell       <= '0;
      dwell_cnt   <= '0;
      sync_pend   <= 1'b0;
      angle       <= '0;
      angle_valid <= 1'b0;
      sync        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      angle_valid <= advance;
      sync        <= advance && sync_pend;
      cfg_err     <= cfg_fire && cfg_bad;
      if (advance) angle <= angle_next;

      // A load wins over a same-cycle advance: the sample goes out, the acc update is dropped.
      if (cfg_fire && !cfg_bad) begin
        ftw       <= cfg_ftw;
        offset    <= cfg_phase;
        step      <= cfg_step;
        stop      <= cfg_stop;
        dwell     <= cfg_dwell;
        acc       <= '0;
        dwell_cnt <= '0;
        sync_pend <= 1'b1;
        state     <= (cfg_sweep && (cfg_stop > cfg_ftw)) ? SWEEP : RUN;
      end else if (advance) begin
        acc       <= acc_next;
        sync_pend <= wrap;
        if (state == SWEEP) begin
          if (dwell_hit) begin
            dwell_cnt <= '0;
            ftw       <= ftw_sat;
            if (ftw_sat == stop) state <= RUN;
          end else begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: hand-computed angle/sync/busy sequences for
// fixed-rate, offset, fractional, rejected-config, sweep and reset scenarios.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_ftw;
  logic [15:0] cfg_phase;
  logic        cfg_sweep;
  logic [31:0] cfg_step;
  logic [31:0] cfg_stop;
  logic [15:0] cfg_dwell;
  logic [15:0] angle;
  logic        angle_valid;
  logic        sync;
  logic        busy;
  logic        cfg_err;

  int checks   = 0;
  int failures = 0;

  int sweep_a [9] = '{0, 100, 200, 350, 500, 700, 900, 1150, 1400};

  dds_phase_gen #(.FRAC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_sweep(cfg_sweep), .cfg_step(cfg_step),
    .cfg_stop(cfg_stop), .cfg_dwell(cfg_dwell), .angle(angle), .angle_valid(angle_valid),
    .sync(sync), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag, input int a, input bit s);
    tick();
    check({tag, ".valid"}, angle_valid, 1);
    check({tag, ".angle"}, angle, a);
    check({tag, ".sync"}, sync, s);
  endtask

  task automatic load(input logic [31:0] ftw, input logic [15:0] ph, input logic sw,
                      input logic [31:0] st, input logic [31:0] sp, input logic [15:0] dw,
                      input logic keep_en);
    en        = keep_en;
    cfg_valid = 1'b1;
    cfg_ftw   = ftw;
    cfg_phase = ph;
    cfg_sweep = sw;
    cfg_step  = st;
    cfg_stop  = sp;
    cfg_dwell = dw;
    tick();
    cfg_valid = 1'b0;
    en        = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".angle"}, angle, 0);
    check({tag, ".valid"}, angle_valid, 0);
    check({tag, ".sync"}, sync, 0);
    check({tag, ".err"}, cfg_err, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".ready"}, cfg_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_ftw = '0; cfg_phase = '0;
    cfg_sweep = 1'b0; cfg_step = '0; cfg_stop = '0; cfg_dwell = '0;
    tick(); tick();
    check_reset("rst");
    rst_n = 1'b1;

    // No samples in IDLE even with en high
    en = 1'b1;
    tick(); check("idle.valid0", angle_valid, 0);
    tick(); check("idle.valid1", angle_valid, 0);

    // Quarter-turn steps
    load(32'd9000 << 16, 16'd0, 1'b0, 32'd0, 32'd0, 16'd0, 1'b0);
    check("q.load_valid", angle_valid, 0);
    sample("q0", 0, 1);
    sample("q1", 9000, 0);
    sample("q2", 18000, 0);
    sample("q3", 27000, 0);
    sample("q4", 0, 1);
    sample("q5", 9000, 0);

    // Out-of-range tuning word rejected while running; sequence unaffected
    load(32'd36000 << 16, 16'd0, 1'b0, 32'd0, 32'd0, 16'd0, 1'b1);
    check("bad.err", cfg_err, 1);
    check("bad.angle", angle, 18000);
    check("bad.valid", angle_valid, 1);
    sample("bad.q7", 27000, 0);
    check("bad.err_pulse", cfg_err, 0);
    sample("bad.q8", 0, 1);

    // en low for three cycles holds everything
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.valid", angle_valid, 0);
      check("hold.sync", sync, 0);
    end
    en = 1'b1;
    sample("hold.r0", 9000, 0);
    sample("hold.r1", 18000, 0);
    en = 1'b0;
    tick();
    check("hold.angle_kept", angle, 18000);

    // Half-turn steps with 270 degree offset
    load(32'd18000 << 16, 16'd27000, 1'b0, 32'd0, 32'd0, 16'd0, 1'b0);
    sample("h0", 27000, 1);
    sample("h1", 9000, 0);
    sample("h2", 27000, 1);
    sample("h3", 9000, 0);

    // Half-centidegree steps
    load(32'h0000_8000, 16'd0, 1'b0, 32'd0, 32'd0, 16'd0, 1'b0);
    sample("f0", 0, 1);
    sample("f1", 0, 0);
    sample("f2", 1, 0);
    sample("f3", 1, 0);
    sample("f4", 2, 0);
    sample("f5", 2, 0);

    // Load colliding with an advance: old sample out, acc restarts from 0
    load(32'd9000 << 16, 16'd0, 1'b0, 32'd0, 32'd0, 16'd0, 1'b1);
    check("col.valid", angle_valid, 1);
    check("col.angle", angle, 3);
    check("col.sync", sync, 0);
    sample("col.n0", 0, 1);
    sample("col.n1", 9000, 0);

    // Linear sweep 100 -> 250 in steps of 50, two samples per step
    load(32'd100 << 16, 16'd0, 1'b1, 32'd50 << 16, 32'd250 << 16, 16'd2, 1'b0);
    check("sw.busy_load", busy, 1);
    check("sw.ready_load", cfg_ready, 0);
    for (int i = 0; i < 9; i++) begin
      sample($sformatf("sw%0d", i), sweep_a[i], i == 0);
      check($sformatf("sw%0d.busy", i), busy, (i < 5) ? 1 : 0);
      check($sformatf("sw%0d.ready", i), cfg_ready, (i < 5) ? 0 : 1);
    end

    // Sweep with out-of-range stop rejected; RUN at 250 continues from acc=1650
    load(32'd100 << 16, 16'd0, 1'b1, 32'd50 << 16, 32'd36000 << 16, 16'd2, 1'b0);
    check("swbad.err", cfg_err, 1);
    check("swbad.busy", busy, 0);
    sample("swbad.cont", 1650, 0);

    // Dwell 0 acts as 1; overshooting step clamps to stop
    load(32'd100 << 16, 16'd0, 1'b1, 32'd150 << 16, 32'd300 << 16, 16'd0, 1'b0);
    sample("d0.s0", 0, 1);
    check("d0.busy0", busy, 1);
    sample("d0.s1", 100, 0);
    check("d0.busy1", busy, 0);
    sample("d0.s2", 350, 0);
    sample("d0.s3", 650, 0);

    // Step large enough to overflow 32 bits still saturates at stop
    load(32'd100 << 16, 16'd0, 1'b1, 32'hFFFF_0000, 32'd300 << 16, 16'd0, 1'b0);
    check("ovf.busy_load", busy, 1);
    sample("ovf.s0", 0, 1);
    check("ovf.busy0", busy, 0);
    sample("ovf.s1", 100, 0);
    sample("ovf.s2", 400, 0);

    // Asynchronous reset in the middle of a sweep
    load(32'd100 << 16, 16'd0, 1'b1, 32'd50 << 16, 32'd250 << 16, 16'd2, 1'b0);
    sample("mr.s0", 0, 1);
    sample("mr.s1", 100, 0);
    #2 rst_n = 1'b0;
    #1 check_reset("mr.async");
    tick();
    rst_n = 1'b1;
    tick(); check("mr.idle0", angle_valid, 0);
    tick(); check("mr.idle1", angle_valid, 0);
    check("mr.busy", busy, 0);
    load(32'd9000 << 16, 16'd4500, 1'b0, 32'd0, 32'd0, 16'd0, 1'b0);
    sample("mr.n0", 4500, 1);
    sample("mr.n1", 13500, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
